div32by16: RTL and testbench
============================

# div32by16

Iterative radix-2 restoring divider, the inverse of the 16-bit pipelined multiplier. It takes a 2N-bit dividend and an N-bit divisor and returns a 2N-bit quotient, an N-bit remainder and a divide-by-zero flag. One quotient bit is produced per clock, over 2N cycles. It sits beside the multiplier in the arithmetic datapath and uses valid/ready handshakes on both input and output, so upstream and downstream stalls never lose data.

## Interface
- N, default 16: divisor/remainder width; dividend/quotient width is 2N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- quotient  output  2N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  set with the result when divisor was 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: iterating.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready with divisor≠0. On that edge:
  - latch dividend into the quotient/shift register and divisor into a divisor register;
  - clear the N+1-bit partial remainder;
  - clear the iteration counter.
- IDLE→DONE on acceptance with divisor==0. On that edge load:
  - quotient=all ones;
  - remainder=dividend[N-1:0];
  - div_by_zero=1.
- RUN, each cycle:
  - shift {partial, q} left by 1, bringing in the dividend MSB;
  - trial = partial − {1'b0,divisor};
  - if trial is non-negative, partial=trial and the new q LSB=1, else the q LSB=0;
  - counter++.
- RUN→DONE after the 2N-th iteration (counter reaches 2N−1). remainder=partial[N-1:0]; div_by_zero=0.
- DONE→IDLE on out_ready.
- While out_valid&&!out_ready, the quotient, remainder and div_by_zero outputs stay stable.
- dividend and divisor are ignored whenever in_ready=0.
- All arithmetic is unsigned. The partial remainder is N+1 bits wide, so the trial subtract cannot overflow.
- Invariants for every non-zero divisor:
  - quotient*divisor+remainder==dividend;
  - remainder<divisor.

## Timing
- Reset (async assert, sync deassert at the top level):
  - state=IDLE;
  - in_ready=1;
  - out_valid=0;
  - quotient=0, remainder=0, div_by_zero=0;
  - counter=0.
- Latency for a non-zero divisor, with acceptance at edge E0: out_valid rises after edge E2N (E32 for N=16).
- Latency for divisor==0: out_valid rises after E0, so 1 cycle.
- Throughput: 2N+2 cycles per operation if out_ready is held high, i.e. accept, 2N RUN cycles, DONE with handshake, then the IDLE acceptance cycle. No overlap between operations.
- in_ready is a function of state only, with no combinational path from in_valid.
- out_valid is a function of state only, with no combinational path from out_ready.
- rst_n asserted mid-RUN or mid-DONE: immediately returns to reset values. The in-flight result is discarded and no out_valid pulse appears.
- In DONE, in_valid is ignored. The next operand pair is accepted no earlier than the cycle after the out handshake.

## Structure
- Package div_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default N=16;
  - counter width $clog2(2N).
- One sub-module, div_step: purely combinational single restoring iteration. Inputs are partial, q, divisor; outputs are next partial and next q. It is instantiated once in the divider.
- The top level holds the FSM, counter and operand/result registers.

## Test plan
- dividend=100, divisor=7 → quotient=14, remainder=2, div_by_zero=0; out_valid first high exactly 32 cycles after the accept edge.
- dividend=0xFFFFFFFF, divisor=0xFFFF → quotient=0x00010001, remainder=0.
- dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0.
- dividend=0x12345678, divisor=0 → div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x5678; out_valid one cycle after acceptance.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored;
  - assert rst_n=0 at RUN cycle 10 → all outputs at reset values, in_ready=1, no stale out_valid.
- Multiplier round-trip with random a,b≠0 → dividend=a*b, divisor=b gives quotient=a, remainder=0. Run 1000 randomized pairs against a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package div_pkg;

    localparam int N_DEF = 16;
    localparam int CNT_W = $clog2(2 * N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift {partial, q} left, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]     partial,
    input  logic [2*N-1:0] q,
    input  logic [N-1:0]   divisor,
    output logic [N:0]     partial_next,
    output logic [2*N-1:0] q_next
);

    logic [N+1:0] shifted;
    logic [N:0]   trial;
    logic         fits;

    always_comb begin
        // partial < divisor holds between iterations, so the shifted value never needs N+2 bits of result
        shifted = {partial, q[2*N-1]};
        fits    = (shifted >= {2'b00, divisor});
        trial   = shifted[N:0] - {1'b0, divisor};
        if (fits) begin
            partial_next = trial;
            q_next       = {q[2*N-2:0], 1'b1};
        end else begin
            partial_next = shifted[N:0];
            q_next       = {q[2*N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32by16.sv
// 2N-by-N unsigned iterative divider, one quotient bit per clock, valid/ready on both sides.
module div32by16
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_ITER = CW'(2 * N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] q_q, q_d;
    logic [N:0]     part_q, part_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     step_part;
    logic [2*N-1:0] step_q;

    div_step #(.N(N)) u_step (
        .partial      (part_q),
        .q            (q_q),
        .divisor      (dvs_q),
        .partial_next (step_part),
        .q_next       (step_q)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = dividend[N-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        dvs_d   = divisor;
                        part_d  = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                part_d = step_part;
                q_d    = step_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    rem_d   = step_part[N-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32by16.sv
// Self-checking bench for div32by16: arithmetic reference model plus directed literal vectors.
module tb_div32by16;
    import div_pkg::*;

    localparam int N = 16;

    typedef struct {
        logic [2*N-1:0] q;
        logic [N-1:0]   r;
        logic           dbz;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];

    div32by16 #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
        res_t r;
        if (b == '0) begin
            r.q   = '1;
            r.r   = a[N-1:0];
            r.dbz = 1'b1;
        end else begin
            r.q   = a / {16'h0000, b};
            r.r   = 16'(a % {16'h0000, b});
            r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Every cycle a result is presented, it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 required 0 (t=%0t)", $time);
            end else begin
                check("model_quotient", 64'(quotient), 64'(exp_q[0].q));
                check("model_remainder", 64'(remainder), 64'(exp_q[0].r));
                check("model_div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dbz));
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the handshake edge.
    task automatic do_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] eq, input logic [N-1:0] er,
                         input logic edbz, input int hold);
        int lat;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        check("out_valid_idle", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = '0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: got no out_valid within %0d cycles required result", lat);
            pulse_reset();
            return;
        end
        check("latency_edges", 64'(lat), (b == '0) ? 64'd0 : 64'd32);
        check("lit_quotient", 64'(quotient), 64'(eq));
        check("lit_remainder", 64'(remainder), 64'(er));
        check("lit_div_by_zero", 64'(div_by_zero), 64'(edbz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = 16'($urandom_range(0, 3));
            @(negedge clk);
            check("backpressure_in_ready", 64'(in_ready), 64'd0);
            check("backpressure_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, prod;
        bit          seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_quotient", 64'(quotient), 64'd0);
        check("reset_remainder", 64'(remainder), 64'd0);
        check("reset_div_by_zero", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0, 0);
        do_op(32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1, 0);
        do_op(32'd7, 16'd100, 32'd0, 16'd7, 1'b0, 0);
        do_op(32'h0000_0000, 16'h0003, 32'd0, 16'd0, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 16'h8000, 32'h0001_FFFF, 16'h7FFF, 1'b0, 0);
        do_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 10);
        do_op(32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1, 10);

        // Abort an operation ten cycles into RUN; nothing from it may surface.
        in_valid = 1'b1;
        dividend = 32'd100;
        divisor  = 16'd7;
        exp_q.push_back(model(32'd100, 16'd7));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        check("midrun_reset_out_valid", 64'(out_valid), 64'd0);
        check("midrun_reset_quotient", 64'(quotient), 64'd0);
        check("midrun_reset_remainder", 64'(remainder), 64'd0);
        check("midrun_reset_div_by_zero", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_stale_out_valid", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 1000; k++) begin
            ra   = 32'($urandom_range(0, 65535));
            rb   = 32'($urandom_range(1, 65535));
            prod = ra * rb;
            do_op(prod, rb[15:0], ra, 16'h0000, 1'b0, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
